// File: rtl/ysyx_23060236_scoreboard_rf_pkg.sv
// Shared defaults for the scoreboarded register file: register-array
// geometry, pending-write counter width and the index of the a0 register
// that drives the return_value port.
package ysyx_23060236_scoreboard_rf_pkg;

    // Register address width: 2**YSYX_ADDR_WIDTH architectural registers.
    localparam int YSYX_ADDR_WIDTH = 4;

    // Width of one architectural register.
    localparam int YSYX_DATA_WIDTH = 32;

    // Pending-write counter width: up to 2**YSYX_CNT_WIDTH-1 in-flight
    // writes per register.
    localparam int YSYX_CNT_WIDTH = 2;

    // a0 is the ABI return-value register; the simulation environment
    // watches it through return_value.
    localparam int YSYX_A0_INDEX = 10;

    // Number of registers for a given address width.
    function automatic int num_regs(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/ysyx_23060236_scoreboard_rf_scoreboard.sv
// Pending-write scoreboard: one saturating counter per architectural
// register. An accepted issue increments, a committing writeback decrements,
// flush clears everything. Also produces the issue-side back-pressure and
// the per-read-port busy flags.
module ysyx_23060236_scoreboard
    import ysyx_23060236_scoreboard_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = YSYX_ADDR_WIDTH,
    parameter int CNT_WIDTH  = YSYX_CNT_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic                  wb_fire,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic                  rbusy1,
    output logic                  rbusy2
);

    localparam int                   NREG    = num_regs(ADDR_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] cnt [NREG];
    logic [NREG-1:0]      inc_vec;
    logic [NREG-1:0]      dec_vec;
    logic                 iss_fire;
    logic                 wb_hit1;
    logic                 wb_hit2;

    // Issue acceptance: stall only when the destination counter is full.
    // A writeback to the same register this cycle does not relieve the stall.
    always_comb begin
        iss_ready = 1'b1;
        if ((iss_rd != '0) && (cnt[iss_rd] == CNT_MAX)) begin
            iss_ready = 1'b0;
        end
        iss_fire = iss_valid & iss_ready & (iss_rd != '0) & ~flush;
    end

    // One-hot increment/decrement requests per register; x0 is never tracked.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment, so no path leaves it unassigned (no latch).
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_vec[r] = iss_fire & (iss_rd == ADDR_WIDTH'(r));
            dec_vec[r] = wb_fire & (wb_addr == ADDR_WIDTH'(r));
        end
    end

    // Counter update: reset and flush clear all; issue and writeback to the
    // same register cancel; a decrement of an idle counter is ignored.
    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments so every
        // counter sees the pre-edge values of its neighbours and inputs.
        if (reset || flush) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    // Busy flags: a register is busy if writes remain pending after the
    // writeback committing this cycle has been accounted for.
    always_comb begin
        wb_hit1 = wb_fire & (wb_addr == raddr1);
        wb_hit2 = wb_fire & (wb_addr == raddr2);
        rbusy1  = (raddr1 != '0) & (cnt[raddr1] > CNT_WIDTH'(wb_hit1));
        rbusy2  = (raddr2 != '0) & (cnt[raddr2] > CNT_WIDTH'(wb_hit2));
    end

endmodule

// File: rtl/ysyx_23060236_scoreboard_rf.sv
// Scoreboarded register file: 2-read/1-write register array with x0
// hard-wired to zero, same-cycle writeback bypass on both read ports, and a
// pending-write scoreboard that flags reads of registers still in flight.
module ysyx_23060236_scoreboard_rf
    import ysyx_23060236_scoreboard_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = YSYX_ADDR_WIDTH,
    parameter int DATA_WIDTH = YSYX_DATA_WIDTH,
    parameter int CNT_WIDTH  = YSYX_CNT_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic                  wb_valid,
    input  logic                  wb_wen,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic                  rbusy1,
    output logic                  rbusy2,
    output logic [DATA_WIDTH-1:0] return_value
);

    localparam int                    NREG    = num_regs(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] A0_ADDR = ADDR_WIDTH'(YSYX_A0_INDEX);

    logic [DATA_WIDTH-1:0] rf [NREG];
    logic                  wb_fire;

    // A writeback commits only when it writes a register other than x0.
    assign wb_fire = wb_valid & wb_wen & (wb_addr != '0);

    // Register array write; x0 is never stored.
    always_ff @(posedge clock) begin
        // NOTE: this array is cleared on reset because software-visible
        // registers must start at zero; a pure storage RAM would skip it.
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                rf[r] <= '0;
            end
        end else if (wb_fire) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Read ports: x0 reads zero, a same-cycle writeback is forwarded,
    // otherwise the stored value is returned.
    always_comb begin
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (wb_fire && (wb_addr == raddr1)) begin
            rdata1 = wb_data;
        end else begin
            rdata1 = rf[raddr1];
        end

        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (wb_fire && (wb_addr == raddr2)) begin
            rdata2 = wb_data;
        end else begin
            rdata2 = rf[raddr2];
        end
    end

    // a0 as stored, without bypass: it changes one cycle after the write.
    assign return_value = rf[A0_ADDR];

    ysyx_23060236_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .wb_fire   (wb_fire),
        .wb_addr   (wb_addr),
        .flush     (flush),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .rbusy1    (rbusy1),
        .rbusy2    (rbusy2)
    );

endmodule

// File: tb/tb_ysyx_23060236_scoreboard_rf.sv
// Self-checking bench for ysyx_23060236_scoreboard_rf with default
// parameters: directed scenarios followed by random traffic, all compared
// against a pending-count/value model kept in plain integer arrays.
module tb_ysyx_23060236_scoreboard_rf;

    logic        clock = 1'b0;
    logic        reset;
    logic        iss_valid;
    logic [3:0]  iss_rd;
    logic        iss_ready;
    logic        wb_valid;
    logic        wb_wen;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic [3:0]  raddr1;
    logic [3:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        rbusy1;
    logic        rbusy2;
    logic [31:0] return_value;

    // Reference model: stored register values and outstanding write counts.
    logic [31:0] m_rf  [16];
    int          m_cnt [16];

    int n_vec = 0;
    int n_err = 0;

    ysyx_23060236_scoreboard_rf dut (
        .clock        (clock),
        .reset        (reset),
        .iss_valid    (iss_valid),
        .iss_rd       (iss_rd),
        .iss_ready    (iss_ready),
        .wb_valid     (wb_valid),
        .wb_wen       (wb_wen),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .flush        (flush),
        .raddr1       (raddr1),
        .raddr2       (raddr2),
        .rdata1       (rdata1),
        .rdata2       (rdata2),
        .rbusy1       (rbusy1),
        .rbusy2       (rbusy2),
        .return_value (return_value)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic wb_commits();
        return wb_valid && wb_wen && (wb_addr != 4'd0);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [3:0] a);
        if (a == 4'd0) return 32'd0;
        if (wb_commits() && wb_addr == a) return wb_data;
        return m_rf[a];
    endfunction

    // Writes still outstanding after this cycle's writeback retires.
    function automatic logic exp_busy(input logic [3:0] a);
        int left;
        if (a == 4'd0) return 1'b0;
        left = m_cnt[a] - ((wb_commits() && wb_addr == a) ? 1 : 0);
        return left > 0;
    endfunction

    // A writeback to a register with nothing outstanding, read on the same
    // port in the same cycle, is left unchecked for busy.
    function automatic logic stray_wb(input logic [3:0] a);
        return wb_commits() && (wb_addr == a) && (m_cnt[a] == 0);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_rf[i]  = 32'd0;
            m_cnt[i] = 0;
        end
    endtask

    // Check every output against the model, take one clock edge, then advance
    // the model by the rules: reset clears all; otherwise a committing
    // writeback stores data; flush forgets all pending writes; an accepted
    // issue adds one pending write, a writeback retires one if any.
    task automatic cycle();
        logic rdy;
        #4;
        rdy = !((iss_rd != 4'd0) && (m_cnt[iss_rd] == 3));
        check("iss_ready", iss_ready, rdy);
        check("rdata1", rdata1, exp_rdata(raddr1));
        check("rdata2", rdata2, exp_rdata(raddr2));
        if (!stray_wb(raddr1)) check("rbusy1", rbusy1, exp_busy(raddr1));
        if (!stray_wb(raddr2)) check("rbusy2", rbusy2, exp_busy(raddr2));
        check("return_value", return_value, m_rf[10]);
        @(posedge clock);
        if (reset) begin
            model_clear();
        end else begin
            if (wb_commits()) m_rf[wb_addr] = wb_data;
            if (flush) begin
                for (int i = 0; i < 16; i++) m_cnt[i] = 0;
            end else begin
                if (iss_valid && rdy && iss_rd != 4'd0) m_cnt[iss_rd] += 1;
                if (wb_commits() && m_cnt[wb_addr] > 0) m_cnt[wb_addr] -= 1;
            end
        end
        #1;
    endtask

    task automatic idle();
        reset     = 1'b0;
        iss_valid = 1'b0;
        iss_rd    = 4'd0;
        wb_valid  = 1'b0;
        wb_wen    = 1'b0;
        wb_addr   = 4'd0;
        wb_data   = 32'd0;
        flush     = 1'b0;
    endtask

    task automatic issue(input logic [3:0] rd);
        iss_valid = 1'b1;
        iss_rd    = rd;
    endtask

    task automatic wb(input logic [3:0] a, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_wen   = 1'b1;
        wb_addr  = a;
        wb_data  = d;
    endtask

    function automatic logic [3:0] rand_addr();
        return ($urandom % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    endfunction

    initial begin
        idle();
        raddr1 = 4'd0;
        raddr2 = 4'd0;
        reset  = 1'b1;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Out of reset: everything idle and zero.
        raddr1 = 4'd10;
        raddr2 = 4'd15;
        #1;
        check("rst_rdata1", rdata1, 32'd0);
        check("rst_rbusy2", rbusy2, 1'b0);
        check("rst_ready", iss_ready, 1'b1);
        check("rst_a0", return_value, 32'd0);
        cycle();

        // Write then read: bypass in the same cycle, array afterwards.
        raddr1 = 4'd5;
        wb(4'd5, 32'h1234);
        #1;
        check("bypass_rdata1", rdata1, 32'h1234);
        check("bypass_a0", return_value, 32'd0);
        cycle();
        idle();
        #1;
        check("array_rdata1", rdata1, 32'h1234);
        cycle();

        // x0: never stored, never busy, never stalls.
        wb(4'd0, 32'hFFFF);
        raddr1 = 4'd0;
        issue(4'd0);
        #1;
        check("x0_rdata1", rdata1, 32'd0);
        check("x0_rbusy1", rbusy1, 1'b0);
        check("x0_ready", iss_ready, 1'b1);
        cycle();
        idle();
        cycle();

        // Saturation on x7.
        raddr1 = 4'd7;
        repeat (3) begin
            issue(4'd7);
            cycle();
        end
        issue(4'd7);
        #1;
        check("sat_ready", iss_ready, 1'b0);
        wb(4'd7, 32'h77);
        #1;
        check("sat_ready_wb", iss_ready, 1'b0);
        iss_valid = 1'b0;
        cycle();
        idle();
        iss_rd = 4'd7;
        #1;
        check("sat_busy_after1", rbusy1, 1'b1);
        check("sat_ready_after1", iss_ready, 1'b1);
        wb(4'd7, 32'h78);
        cycle();
        cycle();
        idle();
        #1;
        check("sat_busy_after3", rbusy1, 1'b0);
        cycle();

        // Simultaneous issue and writeback on x3; stray writeback on x4.
        raddr1 = 4'd3;
        issue(4'd3);
        cycle();
        issue(4'd3);
        wb(4'd3, 32'h33);
        cycle();
        idle();
        #1;
        check("sim_busy_x3", rbusy1, 1'b1);
        wb(4'd4, 32'h44);
        raddr2 = 4'd0;
        cycle();
        idle();
        raddr1 = 4'd4;
        #1;
        check("stray_rdata_x4", rdata1, 32'h44);
        check("stray_busy_x4", rbusy1, 1'b0);
        cycle();

        // Flush with a same-cycle issue and writeback on x9.
        raddr2 = 4'd9;
        issue(4'd9);
        cycle();
        cycle();
        flush = 1'b1;
        wb(4'd9, 32'hAA);
        cycle();
        idle();
        #1;
        check("flush_busy_x9", rbusy2, 1'b0);
        check("flush_rdata_x9", rdata2, 32'hAA);
        cycle();

        // Reset in the middle of activity.
        issue(4'd2);
        cycle();
        issue(4'd11);
        wb(4'd10, 32'h55);
        cycle();
        idle();
        raddr1 = 4'd2;
        #1;
        check("pre_rst_a0", return_value, 32'h55);
        check("pre_rst_busy_x2", rbusy1, 1'b1);
        reset = 1'b1;
        wb(4'd6, 32'h66);
        issue(4'd2);
        cycle();
        idle();
        raddr1 = 4'd5;
        raddr2 = 4'd2;
        #1;
        check("post_rst_a0", return_value, 32'd0);
        check("post_rst_rdata_x5", rdata1, 32'd0);
        check("post_rst_busy_x2", rbusy2, 1'b0);
        raddr2 = 4'd11;
        #1;
        check("post_rst_busy_x11", rbusy2, 1'b0);
        raddr2 = 4'd6;
        #1;
        check("post_rst_rdata_x6", rdata2, 32'd0);
        cycle();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom % 150 == 0);
            flush     = ($urandom % 30 == 0);
            iss_valid = ($urandom % 3 != 0);
            iss_rd    = rand_addr();
            wb_valid  = ($urandom % 4 != 0);
            wb_wen    = ($urandom % 5 != 0);
            wb_addr   = ($urandom % 6 == 0) ? 4'd10 : rand_addr();
            wb_data   = $urandom;
            raddr1    = rand_addr();
            raddr2    = rand_addr();
            cycle();
        end

        idle();
        cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
